// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int MIN_DIV            = 4;
  localparam int DEFAULT_DIV_115200 = 139;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  // Very small dividers leave no room to centre the sample point.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is always visible on dout.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign push_en = push && (!full || pop_en);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with programmable bit divider feeding a FWFT byte FIFO.
//
// state     | meaning
// WAIT_IDLE | line not yet seen high; ignore lows (reset, break, bad stop)
// IDLE      | waiting for start edge
// START     | half a bit in, confirm start bit still low
// DATA      | sample 8 data bits LSB first at bit centres
// STOP      | sample stop bit; 1 pushes the byte, 0 flags a framing error
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEFAULT_DIV = DEFAULT_DIV_115200,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx,
  input  logic             div_we,
  input  logic [31:0]      div_di,
  output logic [31:0]      div_do,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             frame_err,
  output logic             overflow,
  input  logic             clr_err
);

  logic        rx_m;
  logic        rx_s;
  logic [31:0] div_reg;
  logic [31:0] bit_div;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  rx_state_t   state;

  logic cnt_tc;
  logic stop_smp;
  logic push;
  logic stop_bad;
  logic pop;
  logic full;
  logic empty;
  logic ovf_evt;

  assign cnt_tc   = (cnt == '0);
  assign stop_smp = (state == STOP) && cnt_tc;
  assign push     = stop_smp && rx_s;
  assign stop_bad = stop_smp && !rx_s;
  assign pop      = rd_valid && rd_ready;
  assign ovf_evt  = push && full && !pop;
  assign rd_valid = !empty;
  assign div_do   = div_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)     div_reg <= 32'(DEFAULT_DIV);
    else if (div_we) div_reg <= clamp_div(div_di);
  end

  // Timers are down-counters reloaded with (period - 1); the sample happens on terminal count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= WAIT_IDLE;
      bit_div <= 32'(DEFAULT_DIV);
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            bit_div <= div_reg;
            cnt     <= (div_reg >> 1) - 32'd1;
            state   <= START;
          end
        end
        START: begin
          if (cnt_tc) begin
            if (!rx_s) begin
              cnt     <= bit_div - 32'd1;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          if (cnt_tc) begin
            shift[bit_idx] <= rx_s;
            cnt            <= bit_div - 32'd1;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        STOP: begin
          if (cnt_tc) state <= rx_s ? IDLE : WAIT_IDLE;
          else        cnt   <= cnt - 32'd1;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (stop_bad)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovf_evt)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (shift),
    .pop    (pop),
    .dout   (rd_data),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: framing, glitch rejection, overflow, divider updates.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx;
  logic        div_we;
  logic [31:0] div_di;
  logic [31:0] div_do;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  fifo_count;
  logic        frame_err;
  logic        overflow;
  logic        clr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .div_we     (div_we),
    .div_di     (div_di),
    .div_do     (div_do),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_div(input logic [31:0] v);
    div_di = v;
    div_we = 1'b1;
    @(negedge clk);
    div_we = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Leaves the line at the stop-bit level so a break can follow directly.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop;
    repeat (div) @(negedge clk);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    int n = 0;
    while (!rd_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, b);
    pop_one();
  endtask

  initial begin
    resetn   = 1'b0;
    rx       = 1'b1;
    div_we   = 1'b0;
    div_di   = '0;
    rd_ready = 1'b0;
    clr_err  = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);

    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_div", div_do, 139);
    chk("rst_data", rd_data, 0);

    // basic 0x55 at 16 clk/bit
    set_div(16);
    chk("div16", div_do, 16);
    idle(4);
    send_byte(8'h55, 1'b1, 16);
    idle(4);
    chk("b55_valid", rd_valid, 1);
    chk("b55_data", rd_data, 8'h55);
    chk("b55_count", fifo_count, 1);
    chk("b55_ferr", frame_err, 0);
    chk("b55_ovf", overflow, 0);
    pop_one();
    chk("b55_empty", rd_valid, 0);

    // 3-cycle glitch
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    chk("glitch_valid", rd_valid, 0);
    chk("glitch_ferr", frame_err, 0);
    chk("glitch_ovf", overflow, 0);

    // bad stop bit, held break, then recovery
    send_byte(8'hA3, 1'b0, 16);
    idle(40);
    rx = 1'b1;
    idle(20);
    chk("ferr_set", frame_err, 1);
    chk("ferr_drop", rd_valid, 0);
    send_byte(8'h0F, 1'b1, 16);
    idle(4);
    chk("ferr_count", fifo_count, 1);
    expect_byte("b0f", 8'h0F);
    pulse_clr();
    chk("ferr_clr", frame_err, 0);

    // overflow: 9 bytes with no reads
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i), 1'b1, 16);
      idle(2);
    end
    chk("fill_count", fifo_count, 8);
    chk("fill_ovf", overflow, 0);
    send_byte(8'h08, 1'b1, 16);
    idle(4);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 8; i++) expect_byte("drain", 8'(i));
    chk("drain_empty", rd_valid, 0);
    pulse_clr();
    chk("ovf_clr", overflow, 0);

    // full FIFO with pop on the stop-sample cycle: stop sample lands 155 edges after the start edge
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1, 16);
      idle(2);
    end
    chk("full2_count", fifo_count, 8);
    fork
      send_byte(8'h77, 1'b1, 16);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    idle(3);
    chk("pp_count", fifo_count, 8);
    chk("pp_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) expect_byte("pp_drain", 8'h10 + 8'(i));
    expect_byte("pp_last", 8'h77);
    chk("pp_empty", rd_valid, 0);

    // divider clamp and mid-frame update
    set_div(2);
    chk("div_clamp", div_do, 4);
    set_div(16);
    fork
      send_byte(8'h5A, 1'b1, 16);
      begin
        idle(50);
        set_div(32);
      end
    join
    idle(4);
    chk("div32", div_do, 32);
    expect_byte("old_rate", 8'h5A);
    send_byte(8'hC6, 1'b1, 32);
    idle(4);
    expect_byte("new_rate", 8'hC6);

    // reset mid-frame with a byte queued and the line low
    send_byte(8'h3C, 1'b1, 32);
    idle(3);
    chk("pre_rst_count", fifo_count, 1);
    rx = 1'b0;
    idle(20);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    idle(1);
    chk("mrst_count", fifo_count, 0);
    chk("mrst_valid", rd_valid, 0);
    chk("mrst_div", div_do, 139);
    idle(40);
    rx = 1'b1;
    idle(20);
    chk("mrst_low_ignored", rd_valid, 0);
    chk("mrst_ferr", frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
